// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, datapath width and arbiter state encoding
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALUOP_AND     = 4'b0000,
        ALUOP_OR      = 4'b0001,
        ALUOP_ADD     = 4'b0010,
        ALUOP_LESS    = 4'b0100,
        ALUOP_XOR     = 4'b0101,
        ALUOP_SUB     = 4'b0110,
        ALUOP_RSHIFT  = 4'b1000,
        ALUOP_LSHIFT  = 4'b1001,
        ALUOP_NRSHIFT = 4'b1010
    } aluop_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, search starts one past ptr
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            any
);

    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        // k = NREQ wraps back to ptr itself, so the last winner has lowest priority
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational ALU among NREQ requesters
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int XLEN = alu_pkg::XLEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*XLEN-1:0] req_op1,
    input  logic [NREQ*XLEN-1:0] req_op2,
    input  logic [NREQ*4-1:0]    req_alu_op,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [XLEN-1:0]      rsp_result,
    output logic                 rsp_zero,
    output logic [XLEN-1:0]      alu_op1,
    output logic [XLEN-1:0]      alu_op2,
    output logic [3:0]           alu_alu_op,
    input  logic [XLEN-1:0]      alu_result,
    input  logic                 alu_zero,
    output logic                 busy
);

    localparam int IW = idx_width(NREQ);

    arb_state_e      state, state_nxt;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gidx;
    logic [XLEN-1:0] op1_q, op2_q, res_q;
    logic [3:0]      op_q;
    logic            zero_q;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (pick_any)        state_nxt = ST_EXEC;
            ST_EXEC:                      state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready[gidx]) state_nxt = ST_IDLE;
            default:                      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            ptr    <= IW'(NREQ - 1);
            gidx   <= '0;
            op1_q  <= '0;
            op2_q  <= '0;
            op_q   <= '0;
            res_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && pick_any) begin
                gidx  <= pick_idx;
                ptr   <= pick_idx;
                op1_q <= req_op1[pick_idx*XLEN +: XLEN];
                op2_q <= req_op2[pick_idx*XLEN +: XLEN];
                op_q  <= req_alu_op[pick_idx*4 +: 4];
            end
            if (state == ST_EXEC) begin
                res_q  <= alu_result;
                zero_q <= alu_zero;
            end
        end
    end

    // Grant is gated by rst_n so nothing is offered while reset is held
    assign req_ready  = (state == ST_IDLE && rst_n) ? pick_gnt : '0;
    assign rsp_valid  = (state == ST_RESP) ? (NREQ'(1) << gidx) : '0;
    assign busy       = (state != ST_IDLE);
    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;
    assign alu_op1    = op1_q;
    assign alu_op2    = op2_q;
    assign alu_alu_op = op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural ALU and arbiter model
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NREQ = 3;
    localparam int XL   = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*XL-1:0]  req_op1, req_op2;
    logic [NREQ*4-1:0]   req_alu_op;
    logic [XL-1:0]       rsp_result, alu_op1, alu_op2, alu_result;
    logic                rsp_zero, alu_zero, busy;
    logic [3:0]          alu_alu_op;

    int errors = 0;
    int checks = 0;
    int ptr_m;

    alu_arbiter #(.NREQ(NREQ), .XLEN(XL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_alu_op (req_alu_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_alu_op (alu_alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0100: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0101: r = a ^ b;
            4'b1000: r = a >> b[4:0];
            4'b1001: r = a << b[4:0];
            4'b1010: r = 32'($signed(a) >>> b[4:0]);
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), r};
    endfunction

    assign {alu_zero, alu_result} = alu_f(alu_alu_op, alu_op1, alu_op2);

    // Winner = valid requester at the smallest circular distance after the last winner
    function automatic int model_winner(input logic [NREQ-1:0] v, input int p);
        int best, bestd, d;
        best  = -1;
        bestd = NREQ + 1;
        for (int i = 0; i < NREQ; i++) begin
            d = (i - p - 1 + 2 * NREQ) % NREQ;
            if (v[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    function automatic logic [NREQ-1:0] oh(input int w);
        return NREQ'(1) << w;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op1[i*XL +: XL] = a;
        req_op2[i*XL +: XL] = b;
        req_alu_op[i*4 +: 4] = op;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = NREQ - 1;
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge with inputs set; returns just after the edge leaving RESP
    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                          input logic [31:0] er, input logic ez, input int stall,
                          input logic [NREQ-1:0] valid_after, input string nm);
        @(negedge clk);
        chk({nm, " grant"}, req_ready, oh(w));
        chk({nm, " idle busy"}, busy, 0);
        @(posedge clk);
        #1;
        req_valid = valid_after;
        rsp_ready = '0;
        @(negedge clk);
        chk({nm, " exec busy"}, busy, 1);
        chk({nm, " exec rsp_valid"}, rsp_valid, 0);
        chk({nm, " exec ready"}, req_ready, 0);
        chk({nm, " alu_op1"}, alu_op1, a);
        chk({nm, " alu_op2"}, alu_op2, b);
        chk({nm, " alu_op"}, alu_alu_op, op);
        @(posedge clk);
        #1;
        for (int s = 0; s <= stall; s++) begin
            if (s < stall) rsp_ready = NREQ'($urandom) & ~oh(w);
            else           rsp_ready = NREQ'($urandom) | oh(w);
            @(negedge clk);
            chk({nm, " rsp_valid"}, rsp_valid, oh(w));
            chk({nm, " result"}, rsp_result, er);
            chk({nm, " zero"}, rsp_zero, ez);
            chk({nm, " resp ready"}, req_ready, 0);
            chk({nm, " resp busy"}, busy, 1);
            @(posedge clk);
            #1;
        end
        rsp_ready = '0;
        ptr_m = w;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int w, nv, n1, n0;
        logic [NREQ-1:0] v;
        logic [32:0] ez;
        logic [3:0] ops[10];

        tbl[0]  = '{ALUOP_ADD,     32'd5,          32'd7,          32'd12,         1'b0};
        tbl[1]  = '{ALUOP_SUB,     32'd9,          32'd9,          32'd0,          1'b1};
        tbl[2]  = '{ALUOP_XOR,     32'h0000F0F0,   32'h00000F0F,   32'h0000FFFF,   1'b0};
        tbl[3]  = '{ALUOP_LESS,    32'hFFFFFFFF,   32'd1,          32'd1,          1'b0};
        tbl[4]  = '{ALUOP_LESS,    32'd1,          32'hFFFFFFFF,   32'd0,          1'b1};
        tbl[5]  = '{ALUOP_NRSHIFT, 32'h80000000,   32'd4,          32'hF8000000,   1'b0};
        tbl[6]  = '{ALUOP_RSHIFT,  32'h80000000,   32'd4,          32'h08000000,   1'b0};
        tbl[7]  = '{ALUOP_LSHIFT,  32'd1,          32'd31,         32'h80000000,   1'b0};
        tbl[8]  = '{ALUOP_AND,     32'h0000F0F0,   32'h00000FF0,   32'h000000F0,   1'b0};
        tbl[9]  = '{ALUOP_OR,      32'h0000F000,   32'h0000000F,   32'h0000F00F,   1'b0};
        tbl[10] = '{4'hF,          32'd1,          32'd2,          32'd0,          1'b1};

        ops = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h4, 4'h8, 4'h9, 4'hA, 4'h5, 4'hF};

        // Reset with every requester asking
        rst_n      = 1'b0;
        req_valid  = '1;
        rsp_ready  = '0;
        req_op1    = '0;
        req_op2    = '0;
        req_alu_op = '0;
        ptr_m      = NREQ - 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", req_ready, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset rsp_result", rsp_result, 0);
        chk("reset alu_op1", alu_op1, 0);
        #1 rst_n = 1'b1;
        #1 chk("first grant", req_ready, 3'b001);
        req_valid = '0;
        @(posedge clk);
        #1;

        // Directed opcode table through requester 0
        for (int i = 0; i < 11; i++) begin
            set_req(0, tbl[i].op, tbl[i].a, tbl[i].b);
            req_valid = 3'b001;
            run_op(0, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].res, tbl[i].z, i % 3, 3'b000,
                   $sformatf("tbl%0d", i));
        end

        // Round-robin between two continuous requesters
        do_reset();
        set_req(0, ALUOP_SUB, 32'd9, 32'd9);
        set_req(1, ALUOP_XOR, 32'h0000F0F0, 32'h00000F0F);
        req_valid = 3'b011;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) run_op(0, 32'd9, 32'd9, ALUOP_SUB, 32'd0, 1'b1, 0, 3'b011, "rr0");
            else            run_op(1, 32'h0000F0F0, 32'h00000F0F, ALUOP_XOR, 32'h0000FFFF, 1'b0, 0, 3'b011, "rr1");
        end
        req_valid = '0;

        // Backpressure on requester 1 while 0 and 2 wait
        set_req(1, ALUOP_LESS, 32'hFFFFFFFF, 32'd1);
        set_req(0, ALUOP_ADD, 32'd100, 32'd23);
        set_req(2, ALUOP_LSHIFT, 32'd3, 32'd4);
        req_valid = 3'b010;
        run_op(1, 32'hFFFFFFFF, 32'd1, ALUOP_LESS, 32'd1, 1'b0, 10, 3'b101, "bp");
        run_op(2, 32'd3, 32'd4, ALUOP_LSHIFT, 32'd48, 1'b0, 0, 3'b001, "bp next2");
        run_op(0, 32'd100, 32'd23, ALUOP_ADD, 32'd123, 1'b0, 0, 3'b000, "bp next0");

        // Reset during EXEC
        set_req(0, ALUOP_NRSHIFT, 32'h80000000, 32'd4);
        req_valid = 3'b001;
        @(negedge clk);
        chk("midrst grant", req_ready, 3'b001);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        chk("midrst exec busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst rsp_valid", rsp_valid, 0);
        chk("midrst rsp_result", rsp_result, 0);
        chk("midrst alu_op1", alu_op1, 0);
        chk("midrst alu_op", alu_alu_op, 0);
        @(posedge clk);
        #1 chk("midrst held rsp_valid", rsp_valid, 0);
        rst_n = 1'b1;
        ptr_m = NREQ - 1;
        req_valid = 3'b001;
        run_op(0, 32'h80000000, 32'd4, ALUOP_NRSHIFT, 32'hF8000000, 1'b0, 0, 3'b000, "reissue");

        // Requester 1 withdraws before being granted
        set_req(0, ALUOP_ADD, 32'd1, 32'd1);
        set_req(1, ALUOP_ADD, 32'd2, 32'd2);
        req_valid = 3'b001;
        @(negedge clk);
        chk("wd grant0", req_ready, 3'b001);
        @(posedge clk);
        #1 req_valid = 3'b010;
        @(negedge clk);
        chk("wd exec ready", req_ready, 0);
        @(posedge clk);
        #1 req_valid = 3'b000;
        rsp_ready = '1;
        n1 = 0;
        n0 = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid[1] || req_ready[1]) n1++;
            if (rsp_valid[0]) n0++;
        end
        chk("wd req1 served", n1, 0);
        chk("wd req0 responses", n0, 1);
        rsp_ready = '0;
        ptr_m = 0;
        @(posedge clk);
        #1;

        // Randomized traffic against the model
        for (int t = 0; t < 150; t++) begin
            nv = $urandom_range(1, (1 << NREQ) - 1);
            v  = NREQ'(nv);
            for (int i = 0; i < NREQ; i++) begin
                logic [31:0] a, b;
                a = $urandom;
                b = ($urandom_range(0, 3) == 0) ? a : $urandom;
                set_req(i, ops[$urandom_range(0, 9)], a, b);
            end
            w  = model_winner(v, ptr_m);
            ez = alu_f(req_alu_op[w*4 +: 4], req_op1[w*XL +: XL], req_op2[w*XL +: XL]);
            req_valid = v;
            run_op(w, req_op1[w*XL +: XL], req_op2[w*XL +: XL], req_alu_op[w*4 +: 4],
                   ez[31:0], ez[32], $urandom_range(0, 2), 3'b000, $sformatf("rand%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational 32-bit ALU among `NREQ` requesters (e.g. integer pipe, address generator, debug port). Accepts one operation at a time through valid/ready handshakes, grants round-robin, drives the ALU from registered operands, and returns `result`/`zero` to the granted requester with a held response handshake. Sits between the requesting units and the ALU instance; the ALU itself stays outside this block.

## Interface
Parameters:
- `NREQ`, 2, number of requesters (2..8).
- `XLEN`, 32, operand/result width; must match the ALU.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  requester i has an operation pending.
- `req_ready`  out  NREQ  one-hot grant; handshake when `req_valid[i] & req_ready[i]`.
- `req_op1`  in  NREQ*XLEN  packed first operands, slice i = bits [i*XLEN +: XLEN].
- `req_op2`  in  NREQ*XLEN  packed second operands.
- `req_alu_op`  in  NREQ*4  packed 4-bit ALU opcodes.
- `rsp_valid`  out  NREQ  one-hot; response available for requester i.
- `rsp_ready`  in  NREQ  requester i accepts response.
- `rsp_result`  out  XLEN  captured ALU result (shared bus, qualified by `rsp_valid`).
- `rsp_zero`  out  1  captured ALU zero flag.
- `alu_op1`, `alu_op2`  out  XLEN  to ALU operands.
- `alu_alu_op`  out  4  to ALU opcode.
- `alu_result`  in  XLEN  from ALU.
- `alu_zero`  in  1  from ALU.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any `req_valid`, pick winner g by round-robin, assert `req_ready[g]` only (combinational from state, pointer, `req_valid`; never from operands). On the edge: latch g, its op1/op2/alu_op into operand registers, set pointer = g, go EXEC. No valid -> stay IDLE, `req_ready` = 0.
- Round-robin: search starts at pointer+1 mod NREQ; first set `req_valid` wins. Pointer resets to NREQ-1, so requester 0 wins first.
- EXEC: `alu_*` outputs driven from operand registers; on the edge capture `alu_result`/`alu_zero` into response registers, go RESP.
- RESP: `rsp_valid[g]` = 1, held with stable `rsp_result`/`rsp_zero` until `rsp_ready[g]`; then go IDLE. `rsp_ready` of other requesters ignored.
- Outside EXEC, `alu_*` outputs keep the last registered operands (no gratuitous toggling); opcode is not checked — unsupported codes return whatever the ALU yields (0, zero=1).
- Requesters must hold `req_valid` and operands stable until granted; withdrawing valid before grant is legal and simply loses arbitration.

## Timing
- Reset (asynchronous, immediate): state IDLE, pointer NREQ-1, `req_ready` 0, `rsp_valid` 0, `busy` 0, `rsp_result` 0, `rsp_zero` 0, `alu_op1`/`alu_op2` 0, `alu_alu_op` 0.
- Request handshake in cycle 0 -> EXEC in cycle 1 -> `rsp_valid` high from cycle 2. Minimum 3 cycles per operation (accept, execute, respond with `rsp_ready` already high); next grant earliest in cycle 3.
- ALU path is one full cycle: operand registers -> ALU -> response registers.
- `rsp_ready` low stalls indefinitely in RESP; no new grants while stalled.
- Reset mid-operation: in-flight operation and pending response discarded; requester must reissue.
- Simultaneous requests: exactly one `req_ready` bit high per IDLE cycle.

## Structure
- Shared package `alu_pkg`: ALUOP codes (AND 0000, OR 0001, ADD 0010, SUB 0110, LESS 0100, RSHIFT 1000, LSHIFT 1001, NRSHIFT 1010, XOR 0101), XLEN, FSM state encoding.
- One sub-module: `rr_pick` — combinational round-robin picker (inputs `req`, `ptr`; outputs one-hot `gnt`, index `gnt_idx`, `any`).

## Test plan
- Reset: hold `rst_n`=0 with all `req_valid`=1 -> `req_ready`=0, `rsp_valid`=0, `busy`=0; release -> requester 0 granted first cycle.
- Single ADD: req0 op1=5, op2=7, op=0010 -> `rsp_valid[0]` in cycle 2, `rsp_result`=12, `rsp_zero`=0.
- Round-robin: req0 and req1 valid continuously with SUB 9-9 and XOR 0xF0F0^0x0F0F -> grants alternate 0,1,0,1; results 0 (zero=1) and 0x0000FFFF.
- Backpressure: `rsp_ready[1]`=0 for 10 cycles after SLT -1<1 -> `rsp_valid[1]` held, result 1 stable, no new `req_ready` until accepted.
- Reset mid-op: assert `rst_n`=0 during EXEC of NRSHIFT 0x80000000>>>4 -> outputs return to reset values immediately; reissue returns 0xF8000000.
- Withdraw: req1 drops valid before grant while req0 busy -> req1 never receives `rsp_valid`.
